// File: rtl/mem_rd_engine_if.sv
`default_nettype none
// ============================================================================
// Module   : mem_rd_engine_if
// Brief    : Request, local-memory and output-stream signals of mem_rd_engine.
// Revision : 1.0
// ============================================================================
interface mem_rd_engine_if #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 32
);
  logic              req_valid;
  logic              req_ready;
  logic [ADDR_W-1:0] req_addr;
  logic [ADDR_W-1:0] req_len;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_dout;
  logic              dat_valid;
  logic              dat_ready;
  logic [DATA_W-1:0] dat_data;
  logic              dat_last;
  logic              done;
  logic              err;

  modport master (
    output req_valid, req_addr, req_len, mem_dout, dat_ready,
    input  req_ready, mem_we, mem_addr, dat_valid, dat_data, dat_last, done, err
  );

  modport slave (
    input  req_valid, req_addr, req_len, mem_dout, dat_ready,
    output req_ready, mem_we, mem_addr, dat_valid, dat_data, dat_last, done, err
  );
endinterface
`default_nettype wire

// File: rtl/mem_rd_engine.sv
`default_nettype none
// ============================================================================
// Module   : mem_rd_engine
// Brief    : Streams a dword range from a synchronous-read memory through a
//            4-entry FIFO. Define MEM_RD_ERR_EN to reject out-of-range requests.
// Revision : 1.0
// ============================================================================
module mem_rd_engine #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 32
) (
  input wire             clk,
  input wire             rst_n,
  mem_rd_engine_if.slave bus
);

  localparam int c_cnt_w = ADDR_W + 1;
  localparam logic [c_cnt_w-1:0] c_span = {1'b1, {ADDR_W{1'b0}}};

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  state_t             r_state;
  logic [ADDR_W-1:0]  r_mem_addr;
  logic [c_cnt_w-1:0] r_remain;
  logic [c_cnt_w-1:0] r_left;
  logic               r_s0;
  logic               r_s1;
  logic               r_done;
  logic [DATA_W-1:0]  r_fifo [4];
  logic [1:0]         r_wr_ptr;
  logic [1:0]         r_rd_ptr;
  logic [2:0]         r_count;

  logic [c_cnt_w-1:0] w_len_ext;
  logic               w_req_ready;
  logic               w_req_fire;
  logic [3:0]         w_occ;
  logic               w_issue;
  logic               w_dat_valid;
  logic               w_pop;
  logic               w_bad;
  logic               w_err_pulse;

  assign w_len_ext   = (bus.req_len == '0) ? c_span : {1'b0, bus.req_len};
  assign w_req_ready = rst_n && (r_state == S_IDLE);
  assign w_req_fire  = bus.req_valid && w_req_ready;
  // Occupancy counts reads still in the address and memory-output stages.
  assign w_occ       = {1'b0, r_count} + {3'b0, r_s0} + {3'b0, r_s1};
  assign w_issue     = (r_state == S_RUN) && (r_remain != '0) && (w_occ < 4'd4);
  assign w_dat_valid = (r_count != 3'd0);
  assign w_pop       = w_dat_valid && bus.dat_ready;

`ifdef MEM_RD_ERR_EN
  logic r_err;

  assign w_bad = (({1'b0, bus.req_addr} + w_len_ext) > c_span);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_err <= 1'b0;
    end else begin
      r_err <= w_req_fire && w_bad;
    end
  end

  assign w_err_pulse = r_err;
  assign bus.err     = r_err;
`else
  assign w_bad       = 1'b0;
  assign w_err_pulse = 1'b0;
  assign bus.err     = 1'b0;
`endif

  // Storage is left unreset; occupancy alone decides what is visible.
  always_ff @(posedge clk) begin
    if (rst_n && r_s1) begin
      r_fifo[r_wr_ptr] <= bus.mem_dout;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_mem_addr <= '0;
      r_remain   <= '0;
      r_left     <= '0;
      r_s0       <= 1'b0;
      r_s1       <= 1'b0;
      r_done     <= 1'b0;
      r_wr_ptr   <= 2'd0;
      r_rd_ptr   <= 2'd0;
      r_count    <= 3'd0;
    end else begin
      r_done  <= 1'b0;
      r_s1    <= r_s0;
      r_s0    <= 1'b0;
      r_count <= r_count + {2'b0, r_s1} - {2'b0, w_pop};
      if (r_s1) begin
        r_wr_ptr <= r_wr_ptr + 2'd1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 2'd1;
        r_left   <= r_left - c_cnt_w'(1);
      end

      case (r_state)
        S_IDLE: begin
          if (w_req_fire) begin
            r_mem_addr <= bus.req_addr;
            if (w_bad) begin
              r_state <= S_DRAIN;
            end else begin
              // Loading the address register is the first issue.
              r_s0     <= 1'b1;
              r_remain <= w_len_ext - c_cnt_w'(1);
              r_left   <= w_len_ext;
              r_state  <= S_RUN;
            end
          end
        end
        S_RUN: begin
          if (w_issue) begin
            r_mem_addr <= r_mem_addr + ADDR_W'(1);
            r_s0       <= 1'b1;
            r_remain   <= r_remain - c_cnt_w'(1);
            if (r_remain == c_cnt_w'(1)) begin
              r_state <= S_DRAIN;
            end
          end else if (r_remain == '0) begin
            r_state <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          if (w_err_pulse) begin
            r_state <= S_IDLE;
          end else if (w_pop && (r_left == c_cnt_w'(1))) begin
            r_state <= S_IDLE;
            r_done  <= 1'b1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.req_ready = w_req_ready;
  assign bus.mem_we    = 1'b0;
  assign bus.mem_addr  = r_mem_addr;
  assign bus.dat_valid = w_dat_valid;
  assign bus.dat_data  = w_dat_valid ? r_fifo[r_rd_ptr] : '0;
  assign bus.dat_last  = w_dat_valid && (r_left == c_cnt_w'(1));
  assign bus.done      = r_done;

endmodule
`default_nettype wire

// File: tb/tb_mem_rd_engine.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_rd_engine
// Brief    : Self-checking bench for mem_rd_engine (vector table + random requests).
// Revision : 1.0
// ============================================================================
module tb_mem_rd_engine;

  logic clk;
  logic rst_n;

  mem_rd_engine_if #(.ADDR_W(10), .DATA_W(32)) bus ();

  mem_rd_engine #(.ADDR_W(10), .DATA_W(32)) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] mem_f(input logic [9:0] a);
    logic [6:0] lo;
    lo = a[6:0];
    return {9'b0, lo + 7'd1, 9'b0, lo};
  endfunction

  // Synchronous-read memory: data for an address one clock after it is presented.
  always @(posedge clk) bus.mem_dout <= mem_f(bus.mem_addr);

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  logic [32:0] got_q[$];
  int first_n, last_n, done_n, done_cnt, err_cnt, err_n;
  int stall_bad, we_bad, timed_out;
  logic ready_at_done, ready_after_err;

  task automatic run_req(input logic [9:0] a, input logic [9:0] l, input int mode);
    int n, budget, post;
    bit fin, prev_stall, r;
    logic [31:0] pd;
    logic pl;
    got_q.delete();
    first_n = -1; last_n = -1; done_n = -1; err_n = -1;
    done_cnt = 0; err_cnt = 0; stall_bad = 0; we_bad = 0; timed_out = 0;
    ready_at_done = 1'b0; ready_after_err = 1'b0;
    @(negedge clk);
    bus.req_valid = 1'b1; bus.req_addr = a; bus.req_len = l; bus.dat_ready = 1'b0;
    budget = 0;
    while (!bus.req_ready && budget < 50) begin
      @(negedge clk);
      budget++;
    end
    if (!bus.req_ready) begin
      timed_out = 1;
      bus.req_valid = 1'b0;
      return;
    end
    @(posedge clk);
    #1;
    // Keep offering junk requests while busy; they must be ignored.
    bus.req_addr = 10'($urandom);
    bus.req_len  = 10'($urandom);
    n = 0; post = 0; fin = 0; prev_stall = 0; pd = '0; pl = 1'b0;
    while (!fin) begin
      @(negedge clk);
      if (bus.req_ready) bus.req_valid = 1'b0;
      if (prev_stall && (bus.dat_valid !== 1'b1 || bus.dat_data !== pd || bus.dat_last !== pl))
        stall_bad++;
      if (bus.done) begin
        done_cnt++;
        if (done_n < 0) begin
          done_n = n;
          ready_at_done = bus.req_ready;
        end
      end
      if (err_n >= 0 && n == err_n + 1) ready_after_err = bus.req_ready;
      if (bus.err) begin
        err_cnt++;
        if (err_n < 0) err_n = n;
      end
      if (bus.mem_we !== 1'b0) we_bad++;
      case (mode)
        0:       r = 1'b1;
        1:       r = (n % 3 == 0);
        default: r = 1'($urandom_range(0, 1));
      endcase
      bus.dat_ready = r;
      if (bus.dat_valid && r) begin
        got_q.push_back({bus.dat_last, bus.dat_data});
        if (first_n < 0) first_n = n;
        last_n = n;
      end
      prev_stall = bus.dat_valid && !r;
      pd = bus.dat_data;
      pl = bus.dat_last;
      if (done_n >= 0 || err_n >= 0) post++;
      if (post >= 3) fin = 1;
      if (n > 5000) begin
        timed_out = 1;
        fin = 1;
      end
      n++;
    end
    bus.req_valid = 1'b0;
    bus.dat_ready = 1'b0;
  endtask

  // Reference: a request reads dwords addr, addr+1, ... (mod 1024); last flag on the final one.
  task automatic verify(input string tag, input logic [9:0] a, input logic [9:0] l, input int mode);
    int len_e, exp_n, bad_beats;
    bit bad;
    logic [9:0] ai;
    logic [32:0] exp_b;
    len_e = (l == 10'd0) ? 1024 : int'(l);
    bad = 1'b0;
`ifdef MEM_RD_ERR_EN
    bad = (int'(a) + len_e > 1024);
`endif
    exp_n = bad ? 0 : len_e;
    check({tag, "_timeout"}, 64'(timed_out), 64'd0);
    check({tag, "_beats"}, 64'(got_q.size()), 64'(exp_n));
    bad_beats = 0;
    for (int i = 0; i < got_q.size(); i++) begin
      ai = 10'(int'(a) + i);
      exp_b = {(i == exp_n - 1), mem_f(ai)};
      if (got_q[i] !== exp_b) bad_beats++;
    end
    check({tag, "_data_last"}, 64'(bad_beats), 64'd0);
    check({tag, "_done_cnt"}, 64'(done_cnt), bad ? 64'd0 : 64'd1);
    check({tag, "_err_cnt"}, 64'(err_cnt), bad ? 64'd1 : 64'd0);
    check({tag, "_stall_hold"}, 64'(stall_bad), 64'd0);
    check({tag, "_mem_we"}, 64'(we_bad), 64'd0);
    if (exp_n > 0) begin
      check({tag, "_done_lat"}, 64'(done_n - last_n), 64'd1);
      check({tag, "_ready_done"}, 64'(ready_at_done), 64'd1);
    end
    if (bad) check({tag, "_ready_err"}, 64'(ready_after_err), 64'd1);
    if (mode == 0 && exp_n > 0) begin
      check({tag, "_first_lat"}, 64'(first_n), 64'd2);
      check({tag, "_no_bubble"}, 64'(last_n - first_n), 64'(exp_n - 1));
    end
  endtask

  typedef struct {
    logic [9:0]  addr;
    logic [9:0]  len;
    int          mode;
    int          exp_beats;
    logic [31:0] exp_first;
    logic [31:0] exp_last;
  } vec_t;

  vec_t vecs[6];

  initial begin
    int beats, budget, v_cnt, d_cnt, e_cnt;
    logic [9:0] ra, rl;
    int rm;

    vecs[0] = '{10'h005, 10'd4, 0, 4, 32'h00060005, 32'h00090008};
    vecs[1] = '{10'h010, 10'd8, 1, 8, 32'h00110010, 32'h00180017};
`ifdef MEM_RD_ERR_EN
    vecs[2] = '{10'h3FE, 10'd4, 0, 0, 32'h0, 32'h0};
`else
    vecs[2] = '{10'h3FE, 10'd4, 0, 4, 32'h007F007E, 32'h00020001};
`endif
    vecs[3] = '{10'h000, 10'd0, 0, 1024, 32'h00010000, 32'h0000007F};
    vecs[4] = '{10'h123, 10'd1, 0, 1, 32'h00240023, 32'h00240023};
    vecs[5] = '{10'h3FF, 10'd1, 2, 1, 32'h0000007F, 32'h0000007F};

    rst_n = 1'b0;
    bus.req_valid = 1'b0; bus.req_addr = '0; bus.req_len = '0; bus.dat_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_req_ready", 64'(bus.req_ready), 64'd0);
    check("rst_mem_addr", 64'(bus.mem_addr), 64'd0);
    check("rst_mem_we", 64'(bus.mem_we), 64'd0);
    check("rst_dat_valid", 64'(bus.dat_valid), 64'd0);
    check("rst_dat_data", 64'(bus.dat_data), 64'd0);
    check("rst_dat_last", 64'(bus.dat_last), 64'd0);
    check("rst_done", 64'(bus.done), 64'd0);
    check("rst_err", 64'(bus.err), 64'd0);
    rst_n = 1'b1;
    #1;
    check("rel_req_ready", 64'(bus.req_ready), 64'd1);

    for (int i = 0; i < 6; i++) begin
      run_req(vecs[i].addr, vecs[i].len, vecs[i].mode);
      verify($sformatf("vec%0d", i), vecs[i].addr, vecs[i].len, vecs[i].mode);
      check($sformatf("vec%0d_tbl_beats", i), 64'(got_q.size()), 64'(vecs[i].exp_beats));
      if (vecs[i].exp_beats > 0 && got_q.size() > 0) begin
        check($sformatf("vec%0d_tbl_first", i), 64'(got_q[0][31:0]), 64'(vecs[i].exp_first));
        check($sformatf("vec%0d_tbl_last", i), 64'(got_q[got_q.size()-1][31:0]), 64'(vecs[i].exp_last));
      end
    end

    // Reset after the second beat of a len=6 request.
    @(negedge clk);
    bus.req_valid = 1'b1; bus.req_addr = 10'h020; bus.req_len = 10'd6; bus.dat_ready = 1'b1;
    budget = 0;
    while (!bus.req_ready && budget < 50) begin
      @(negedge clk);
      budget++;
    end
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
    beats = 0; budget = 0;
    while (beats < 2 && budget < 50) begin
      @(negedge clk);
      if (bus.dat_valid) beats++;
      budget++;
    end
    check("mid_rst_beats", 64'(beats), 64'd2);
    @(posedge clk);
    @(negedge clk);
    bus.dat_ready = 1'b0;
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    bus.dat_ready = 1'b1;
    v_cnt = 0; d_cnt = 0; e_cnt = 0;
    for (int c = 0; c < 20; c++) begin
      if (bus.dat_valid) v_cnt++;
      if (bus.done) d_cnt++;
      if (bus.err) e_cnt++;
      @(negedge clk);
    end
    check("mid_rst_valid", 64'(v_cnt), 64'd0);
    check("mid_rst_done", 64'(d_cnt), 64'd0);
    check("mid_rst_err", 64'(e_cnt), 64'd0);
    bus.dat_ready = 1'b0;
    run_req(10'h040, 10'd5, 0);
    verify("post_rst", 10'h040, 10'd5, 0);

    for (int k = 0; k < 25; k++) begin
      ra = 10'($urandom_range(0, 1023));
      rl = 10'($urandom_range(1, 40));
      rm = (k % 4 == 0) ? 0 : 2;
      run_req(ra, rl, rm);
      verify($sformatf("rnd%0d", k), ra, rl, rm);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/mem_rd_engine.md
MEM_RD_ENGINE -- requirements
Module: mem_rd_engine

Interface
REQ-001 Parameter ADDR_W, default 10, is the local-memory dword address width.
REQ-002 Parameter DATA_W, default 32, is the local-memory data width.
REQ-003 Port clk, input, 1: the single clock; all logic on its rising edge.
REQ-004 Port rst_n, input, 1: reset, synchronous and active-low.
REQ-005 Port req_valid, input, 1: a read request is present.
REQ-006 Port req_ready, output, 1: the engine accepts a request this cycle.
REQ-007 Port req_addr, input, ADDR_W: start dword address.
REQ-008 Port req_len, input, ADDR_W: dword count; 0 encodes 2^ADDR_W.
REQ-009 Port mem_we, output, 1: write enable to local memory, constant 0.
REQ-010 Port mem_addr, output, ADDR_W: registered read address to local memory.
REQ-011 Port mem_dout, input, DATA_W: local-memory read data, valid one clk after mem_addr is presented.
REQ-012 Port dat_valid, output, 1: output beat valid.
REQ-013 Port dat_ready, input, 1: downstream accepts the beat.
REQ-014 Port dat_data, output, DATA_W: output beat data.
REQ-015 Port dat_last, output, 1: marks the final beat of a request.
REQ-016 Port done, output, 1: one-cycle pulse after the last beat handshake.
REQ-017 Port err, output, 1: one-cycle pulse on a rejected request (MEM_RD_ERR_EN only; tied 0 otherwise).

Function
REQ-018 The engine SHALL use the states IDLE, RUN and DRAIN; req_ready SHALL be 1 only in IDLE.
REQ-019 A request handshake (req_valid & req_ready) SHALL load mem_addr<=req_addr and the remaining-issue count<=len, and go to RUN.
REQ-020 In RUN, a read SHALL issue (mem_addr advances by 1, modulo 2^ADDR_W) only when buffer occupancy + in-flight reads < 4.
REQ-021 In-flight tracking SHALL cover two stages (address register, memory output register); mem_dout SHALL be written into a 4-entry FIFO exactly two edges after its issue.
REQ-022 After the final issue, the state SHALL change to DRAIN; when the last beat handshakes it SHALL return to IDLE and assert done for one cycle.
REQ-023 With dat_ready held high, the first dat_valid SHALL appear two edges after the request-handshake edge; thereafter one beat per cycle, with no bubbles.
REQ-024 dat_valid/dat_data/dat_last SHALL hold stable while dat_valid=1 and dat_ready=0; no beat is lost or duplicated under any dat_ready pattern.
REQ-025 dat_last SHALL be 1 on exactly the len-th beat; len=1 yields a single beat with dat_last=1.
REQ-026 A new request SHALL NOT be accepted until done has pulsed; req_valid in RUN/DRAIN SHALL be ignored.

Reset
REQ-027 With rst_n=0 at an edge, the engine SHALL enter IDLE, empty the FIFO, clear the in-flight count and discard in-flight data.
REQ-028 Reset values: req_ready=0 while rst_n=0 and 1 on the first cycle after release; mem_addr=0, mem_we=0, dat_valid=0, dat_data=0, dat_last=0, done=0, err=0.
REQ-029 Reset mid-request SHALL produce no further beats, no done and no err.

Configuration
REQ-030 Macro MEM_RD_ERR_EN defined: a request with req_addr + len > 2^ADDR_W SHALL be accepted, produce no beats, pulse err for one cycle, and return to IDLE on the next cycle.
REQ-031 Macro MEM_RD_ERR_EN undefined: such a request SHALL wrap mem_addr modulo 2^ADDR_W and deliver all len beats; err is constant 0.

Verification
REQ-032 Dummy memory model (data = {9'b0, a[6:0]+1, 9'b0, a[6:0]}), req addr=0x005, len=4, dat_ready=1 -> beats 0x00060005, 0x00070006, 0x00080007, 0x00090008; last on beat 4; done one cycle after.
REQ-033 addr=0x010, len=8, dat_ready toggled 1,0,0,1,... -> 8 beats in order 0x00110010..0x00180017, each held while stalled, none lost.
REQ-034 addr=0x3FE, len=4 -> without macro, beats for addr 0x3FE, 0x3FF, 0x000, 0x001; with MEM_RD_ERR_EN, err pulses once, zero beats, req_ready returns to 1.
REQ-035 len=0 (1024 dwords), addr=0, dat_ready=1 -> 1024 beats, back-to-back, dat_last on beat 1024 only.
REQ-036 rst_n=0 for one cycle after beat 2 of a len=6 request -> no further dat_valid, done=0, and a new request afterwards completes normally.
